spi_ram_arbiter: RTL and testbench

Controller that sequences and shares one single-port RAM between two requesters: the SPI slave command stream (10-bit rx_data/rx_valid words, tx_data/tx_valid return) and a local host port. It decodes SPI commands, holds the SPI write and read address registers, and arbitrates round-robin between SPI and host. It drives the RAM port and returns read data to the proper requester.

---
 rtl/spi_ram_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_arbiter.sv
// Shares one single-port RAM between an SPI command stream and a local host port.
// SPI commands are decoded into a one-deep pending slot, and a round-robin pointer picks between SPI and host.
module spi_ram_arbiter #(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [7:0]           host_wdata,
    output logic                 host_gnt,
    output logic [7:0]           host_rdata,
    output logic                 host_rvalid,
    output logic                 spi_ovf,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata
);

    localparam int unsigned DATA_W = 8;

    if (MEM_DEPTH != (32'd1 << ADDR_SIZE)) begin : g_depth_check
        $error("MEM_DEPTH must equal 2**ADDR_SIZE");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RD_WAIT} state_e;

    state_e                state_q, state_d;
    logic [ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic                  pend_q, pend_d, pend_we_q, pend_we_d;
    logic [ADDR_SIZE-1:0]  pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]     pend_data_q, pend_data_d;
    logic                  ovf_q, ovf_d;
    logic                  rr_host_q, rr_host_d;
    logic                  src_host_q, src_host_d, is_rd_q, is_rd_d;
    logic                  ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [ADDR_SIZE-1:0]  ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]     ram_wdata_q, ram_wdata_d;
    logic                  host_gnt_q, host_gnt_d, host_rvalid_q, host_rvalid_d;
    logic [DATA_W-1:0]     host_rdata_q, host_rdata_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0]     tx_data_q, tx_data_d;

    logic                  pick_host, spi_grant, tx_set;
    logic [1:0]            cmd;
    logic [DATA_W-1:0]     payload;

    assign cmd     = rx_data[9:8];
    assign payload = rx_data[7:0];

    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        pend_d        = pend_q;
        pend_we_d     = pend_we_q;
        pend_addr_d   = pend_addr_q;
        pend_data_d   = pend_data_q;
        ovf_d         = ovf_q;
        rr_host_d     = rr_host_q;
        src_host_d    = src_host_q;
        is_rd_d       = is_rd_q;
        ram_en_d      = ram_en_q;
        ram_we_d      = ram_we_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        host_gnt_d    = 1'b0;
        host_rvalid_d = 1'b0;
        host_rdata_d  = host_rdata_q;
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
        pick_host     = 1'b0;
        spi_grant     = 1'b0;
        tx_set        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (host_req || pend_q) begin
                    // rr_host_q set means the host was not served last and wins a tie
                    pick_host  = host_req && (!pend_q || rr_host_q);
                    spi_grant  = !pick_host;
                    ram_en_d   = 1'b1;
                    host_gnt_d = pick_host;
                    if (pick_host) begin
                        ram_we_d    = host_we;
                        ram_addr_d  = host_addr;
                        ram_wdata_d = host_wdata;
                    end else begin
                        ram_we_d    = pend_we_q;
                        ram_addr_d  = pend_addr_q;
                        ram_wdata_d = pend_data_q;
                    end
                    src_host_d = pick_host;
                    is_rd_d    = !ram_we_d;
                    rr_host_d  = !pick_host;
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ram_en_d = 1'b0;
                state_d  = is_rd_q ? S_RD_WAIT : S_IDLE;
            end
            S_RD_WAIT: begin
                if (src_host_q) begin
                    host_rdata_d  = ram_rdata;
                    host_rvalid_d = 1'b1;
                end else begin
                    tx_data_d = ram_rdata;
                    tx_set    = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (spi_grant) pend_d = 1'b0;

        // SPI command decode; a grant on this same edge frees the slot for a new op
        if (rx_valid) begin
            tx_valid_d = 1'b0;
            case (cmd)
                2'b00: wr_addr_d = ADDR_SIZE'(payload);
                2'b10: rd_addr_d = ADDR_SIZE'(payload);
                default: begin
                    if (!pend_q || spi_grant) begin
                        pend_d      = 1'b1;
                        pend_we_d   = (cmd == 2'b01);
                        pend_addr_d = (cmd == 2'b01) ? wr_addr_q : rd_addr_q;
                        pend_data_d = payload;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            endcase
        end

        if (tx_set) tx_valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            pend_q        <= 1'b0;
            pend_we_q     <= 1'b0;
            pend_addr_q   <= '0;
            pend_data_q   <= '0;
            ovf_q         <= 1'b0;
            rr_host_q     <= 1'b1;
            src_host_q    <= 1'b0;
            is_rd_q       <= 1'b0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            host_gnt_q    <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            pend_q        <= pend_d;
            pend_we_q     <= pend_we_d;
            pend_addr_q   <= pend_addr_d;
            pend_data_q   <= pend_data_d;
            ovf_q         <= ovf_d;
            rr_host_q     <= rr_host_d;
            src_host_q    <= src_host_d;
            is_rd_q       <= is_rd_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            host_gnt_q    <= host_gnt_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign host_gnt    = host_gnt_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign spi_ovf     = ovf_q;
    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a behavioural RAM and queue-based scoreboards
// for RAM writes, host read data and SPI read data.
module tb_spi_ram_arbiter;

    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic          host_gnt;
    logic [7:0]    host_rdata;
    logic          host_rvalid;
    logic          spi_ovf;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    always #5 clk = ~clk;

    spi_ram_arbiter #(.ADDR_SIZE(AW), .MEM_DEPTH(256)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .spi_ovf(spi_ovf),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Single-port RAM: read data appears the cycle after the access
    logic [7:0] mem [256];
    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] tq[$];
    logic [7:0] hq[$];
    int         vectors     = 0;
    int         miscompares = 0;
    logic       tx_prev     = 1'b0;
    int         lat;
    int         cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then score any RAM write, host read return or new SPI read return
    task automatic tick();
        wr_t        e;
        logic [7:0] d;
        @(posedge clk);
        #1;
        if (ram_en === 1'b1 && ram_we === 1'b1) begin
            vectors++;
            assert (wq.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_ram_write observed addr=0x%0h data=0x%0h expected none", ram_addr, ram_wdata);
            end
            if (wq.size() != 0) begin
                e = wq.pop_front();
                chk("ram_wr_addr", 32'(ram_addr), 32'(e.addr));
                chk("ram_wr_data", 32'(ram_wdata), 32'(e.data));
            end
        end
        if (host_rvalid === 1'b1) begin
            vectors++;
            assert (hq.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_host_rvalid observed data=0x%0h expected none", host_rdata);
            end
            if (hq.size() != 0) begin
                d = hq.pop_front();
                chk("host_rdata", 32'(host_rdata), 32'(d));
            end
        end
        if (tx_valid === 1'b1 && tx_prev !== 1'b1) begin
            vectors++;
            assert (tq.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_tx_valid observed data=0x%0h expected none", tx_data);
            end
            if (tq.size() != 0) begin
                d = tq.pop_front();
                chk("tx_data", 32'(tx_data), 32'(d));
            end
        end
        tx_prev = tx_valid;
    endtask

    task automatic spi_word(input logic [9:0] w);
        rx_data  = w;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic host_access(input logic we, input logic [7:0] a, input logic [7:0] d, output int l);
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        host_req   = 1'b1;
        l = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            l++;
            if (host_gnt === 1'b1) break;
        end
        host_req = 1'b0;
        chk("host_gnt_seen", 32'(host_gnt), 32'd1);
    endtask

    initial begin
        // Reset with busy inputs
        rst = 1'b1; rx_data = 10'h1FF; rx_valid = 1'b1;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'hFF; host_wdata = 8'hFF;
        tick(); tick();
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_host_gnt", 32'(host_gnt), 32'd0);
        chk("rst_host_rdata", 32'(host_rdata), 32'd0);
        chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_spi_ovf", 32'(spi_ovf), 32'd0);
        rx_valid = 1'b0; rx_data = '0; host_req = 1'b0;
        rst = 1'b0;
        tick(); tick(); tick();
        chk("idle_ram_en", 32'(ram_en), 32'd0);

        // SPI write A5 to address 5, then read it back
        wq.push_back('{addr: 8'h05, data: 8'hA5});
        spi_word(10'h005);
        spi_word(10'h1A5);
        tick(); tick(); tick();
        spi_word(10'h205);
        tq.push_back(8'hA5);
        spi_word(10'h300);
        tick();
        chk("spi_rd_ram_en", 32'(ram_en), 32'd1);
        chk("spi_rd_ram_we", 32'(ram_we), 32'd0);
        chk("spi_rd_ram_addr", 32'(ram_addr), 32'h05);
        tick(); tick();
        chk("spi_rd_tx_valid", 32'(tx_valid), 32'd1);
        tick(); tick();
        chk("tx_valid_held", 32'(tx_valid), 32'd1);

        // Host write then read of 0x10 while tx_valid stays up
        wq.push_back('{addr: 8'h10, data: 8'h3C});
        host_access(1'b1, 8'h10, 8'h3C, lat);
        chk("host_wr_latency", 32'(lat), 32'd1);
        tick();
        chk("host_gnt_one_cycle", 32'(host_gnt), 32'd0);
        hq.push_back(8'h3C);
        host_access(1'b0, 8'h10, 8'h00, lat);
        chk("host_rd_latency", 32'(lat), 32'd1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (host_rvalid === 1'b1) cnt++;
        end
        chk("host_rvalid_pulses", 32'(cnt), 32'd1);
        chk("tx_valid_unchanged", 32'(tx_valid), 32'd1);
        chk("tx_data_unchanged", 32'(tx_data), 32'hA5);
        spi_word(10'h000);
        chk("tx_valid_cleared_by_rx", 32'(tx_valid), 32'd0);

        // Contention out of reset: host first, then SPI; rounds alternate
        rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
        spi_word(10'h020);
        spi_word(10'h177);
        wq.push_back('{addr: 8'h30, data: 8'h11});
        wq.push_back('{addr: 8'h20, data: 8'h77});
        host_access(1'b1, 8'h30, 8'h11, lat);
        chk("cont1_host_first", 32'(lat), 32'd1);
        tick(); tick(); tick(); tick();
        spi_word(10'h188);
        wq.push_back('{addr: 8'h31, data: 8'h22});
        wq.push_back('{addr: 8'h20, data: 8'h88});
        host_access(1'b1, 8'h31, 8'h22, lat);
        chk("cont2_host_first", 32'(lat), 32'd1);
        tick(); tick(); tick(); tick();
        wq.push_back('{addr: 8'h32, data: 8'h33});
        host_access(1'b1, 8'h32, 8'h33, lat);
        tick();
        spi_word(10'h199);
        wq.push_back('{addr: 8'h20, data: 8'h99});
        wq.push_back('{addr: 8'h33, data: 8'h44});
        host_access(1'b1, 8'h33, 8'h44, lat);
        chk("cont3_spi_first", 32'(lat), 32'd3);
        tick();
        chk("no_ovf_yet", 32'(spi_ovf), 32'd0);

        // Overflow: second SPI write lands while the first waits behind a host access
        wq.push_back('{addr: 8'h40, data: 8'h55});
        wq.push_back('{addr: 8'h20, data: 8'hAA});
        host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h55; host_req = 1'b1;
        rx_data = 10'h1AA; rx_valid = 1'b1;
        tick();
        chk("ovf_host_gnt", 32'(host_gnt), 32'd1);
        host_req = 1'b0;
        rx_data = 10'h1BB;
        tick();
        rx_valid = 1'b0; rx_data = '0;
        chk("spi_ovf_set", 32'(spi_ovf), 32'd1);
        for (int i = 0; i < 6; i++) tick();
        chk("ovf_writes_done", 32'(wq.size()), 32'd0);
        chk("spi_ovf_sticky", 32'(spi_ovf), 32'd1);

        // Reset while an SPI read sits in RD_WAIT
        spi_word(10'h220);
        spi_word(10'h300);
        tick();
        chk("midrst_ram_en", 32'(ram_en), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
        chk("midrst_spi_ovf", 32'(spi_ovf), 32'd0);
        chk("midrst_ram_en_off", 32'(ram_en), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_no_late_tx", 32'(tx_valid), 32'd0);
        wq.push_back('{addr: 8'h50, data: 8'h66});
        host_access(1'b1, 8'h50, 8'h66, lat);
        chk("midrst_idle_latency", 32'(lat), 32'd1);
        tick(); tick();

        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("tq_drained", 32'(tq.size()), 32'd0);
        chk("hq_drained", 32'(hq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
